// File: rtl/alu_seq_unit_if.sv
// Request/result bus of the sequential ALU: request handshake with opcode
// and operands in one direction, result handshake with result words and
// status in the other.
interface alu_seq_unit_if #(
  parameter int DATA_W = 32
);
  logic              i_valid;
  logic              o_ready;
  logic [5:0]        i_Op;
  logic [5:0]        i_funct;
  logic [DATA_W-1:0] i_a;
  logic [DATA_W-1:0] i_b;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_result;
  logic [DATA_W-1:0] o_hi;
  logic [3:0]        o_ALUCtrl;
  logic              o_zero;
  logic              o_illegal;

  modport slave (
    input  i_valid, i_Op, i_funct, i_a, i_b, i_ready,
    output o_ready, o_valid, o_result, o_hi, o_ALUCtrl, o_zero, o_illegal
  );

  modport master (
    output i_valid, i_Op, i_funct, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_result, o_hi, o_ALUCtrl, o_zero, o_illegal
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle integer ops plus an iterative multiplier
// (shift-add) and restoring divider, one bit per cycle. Signed mult/div run
// on magnitudes and apply the sign on the final iteration.
module alu_seq_unit #(
  parameter int DATA_W    = 32,
  parameter int MULDIV_EN = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  alu_seq_unit_if.slave bus
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = SH_W + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {K_ALU, K_ZERO, K_ILL, K_MUL, K_MULU, K_DIV, K_DIVU} kind_t;

  state_t state, state_nxt;

  kind_t             dec_kind;
  logic [3:0]        dec_code;
  logic [DATA_W-1:0] alu_res;
  logic              accept;
  logic              dec_md, dec_signed, dec_div;

  logic [3:0]        ctrl_q;
  logic              illegal_q;
  logic [DATA_W-1:0] result_q, hi_q;
  logic [CNT_W-1:0]  cnt;
  logic              last_iter;

  // Iteration registers: hi = partial product / remainder,
  // lo = multiplier / dividend-then-quotient, op = multiplicand / divisor.
  logic [DATA_W-1:0] work_hi, work_lo, work_op;
  logic              div_q, neg_lo, neg_hi, div0;

  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_sh;
  logic              div_ge;
  logic [DATA_W-1:0] step_hi, step_lo;
  logic [DATA_W-1:0] fin_result, fin_hi;
  logic [2*DATA_W-1:0] prod;

  logic signed [DATA_W-1:0] a_s, b_s;

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
    return (~v) + DATA_W'(1);
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v);
    return (~v) + (2*DATA_W)'(1);
  endfunction

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? neg_w(v) : v;
  endfunction

  assign a_s        = bus.i_a;
  assign b_s        = bus.i_b;
  assign accept     = bus.i_valid && (state == IDLE);
  assign dec_md     = (dec_kind == K_MUL) || (dec_kind == K_MULU) ||
                      (dec_kind == K_DIV) || (dec_kind == K_DIVU);
  assign dec_signed = (dec_kind == K_MUL) || (dec_kind == K_DIV);
  assign dec_div    = (dec_kind == K_DIV) || (dec_kind == K_DIVU);
  assign last_iter  = (cnt == CNT_W'(DATA_W - 1));

  // Decode {Op, funct} into the ALU control code and operation class.
  always_comb begin
    dec_code = 4'b0000;
    dec_kind = K_ILL;
    case (bus.i_Op)
      6'b000000: begin
        case (bus.i_funct)
          6'b100000: begin dec_code = 4'b1000; dec_kind = K_ALU; end
          6'b100010: begin dec_code = 4'b1001; dec_kind = K_ALU; end
          6'b100100: begin dec_code = 4'b1100; dec_kind = K_ALU; end
          6'b100101: begin dec_code = 4'b1101; dec_kind = K_ALU; end
          6'b100110: begin dec_code = 4'b1111; dec_kind = K_ALU; end
          6'b101010: begin dec_code = 4'b0101; dec_kind = K_ALU; end
          6'b000000: begin dec_code = 4'b0000; dec_kind = K_ALU; end
          6'b000010: begin dec_code = 4'b0001; dec_kind = K_ALU; end
          6'b011000: if (MULDIV_EN != 0) begin dec_code = 4'b0010; dec_kind = K_MUL;  end
          6'b011001: if (MULDIV_EN != 0) begin dec_code = 4'b0011; dec_kind = K_MULU; end
          6'b011010: if (MULDIV_EN != 0) begin dec_code = 4'b0110; dec_kind = K_DIV;  end
          6'b011011: if (MULDIV_EN != 0) begin dec_code = 4'b0111; dec_kind = K_DIVU; end
          default: ;
        endcase
      end
      6'b001000: begin dec_code = 4'b1000; dec_kind = K_ALU; end
      6'b001010: begin dec_code = 4'b0101; dec_kind = K_ALU; end
      6'b001100: begin dec_code = 4'b1100; dec_kind = K_ALU; end
      6'b001101: begin dec_code = 4'b1101; dec_kind = K_ALU; end
      6'b001110: begin dec_code = 4'b1111; dec_kind = K_ALU; end
      6'b100011: begin dec_code = 4'b1000; dec_kind = K_ALU; end
      6'b101011: begin dec_code = 4'b1000; dec_kind = K_ALU; end
      6'b000100: begin dec_code = 4'b1001; dec_kind = K_ALU; end
      6'b000101: begin dec_code = 4'b1001; dec_kind = K_ALU; end
      6'b000010: begin dec_code = 4'b0000; dec_kind = K_ZERO; end
      default: ;
    endcase
  end

  // Single-cycle result; jump and illegal requests produce zero.
  always_comb begin
    alu_res = '0;
    if (dec_kind == K_ALU) begin
      case (dec_code)
        4'b1000: alu_res = bus.i_a + bus.i_b;
        4'b1001: alu_res = bus.i_a - bus.i_b;
        4'b1100: alu_res = bus.i_a & bus.i_b;
        4'b1101: alu_res = bus.i_a | bus.i_b;
        4'b1111: alu_res = bus.i_a ^ bus.i_b;
        4'b0101: alu_res = (a_s < b_s) ? DATA_W'(1) : '0;
        4'b0000: alu_res = bus.i_a << bus.i_b[SH_W-1:0];
        4'b0001: alu_res = bus.i_a >> bus.i_b[SH_W-1:0];
        default: alu_res = '0;
      endcase
    end
  end

  // One multiply or restoring-divide step, plus the sign-fixed final values.
  always_comb begin
    mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, work_op} : '0);
    div_sh  = {work_hi, work_lo[DATA_W-1]};
    div_ge  = (div_sh >= {1'b0, work_op});
    if (div_q) begin
      step_hi = div_ge ? (div_sh[DATA_W-1:0] - work_op) : div_sh[DATA_W-1:0];
      step_lo = {work_lo[DATA_W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], work_lo[DATA_W-1:1]};
    end
    prod = {step_hi, step_lo};
    if (neg_lo) prod = neg_2w(prod);
    if (div_q) begin
      fin_result = div0 ? '1 : (neg_lo ? neg_w(step_lo) : step_lo);
      fin_hi     = neg_hi ? neg_w(step_hi) : step_hi;
    end else begin
      fin_result = prod[DATA_W-1:0];
      fin_hi     = prod[2*DATA_W-1:DATA_W];
    end
  end

  // Control state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: accept only in IDLE, iterate DATA_W cycles, hold until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.i_valid) state_nxt = dec_md ? BUSY : DONE;
      BUSY: if (last_iter)   state_nxt = DONE;
      DONE: if (bus.i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture request at acceptance, then step the multiply/divide datapath.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q    <= 4'b0000;
      illegal_q <= 1'b0;
      result_q  <= '0;
      hi_q      <= '0;
      cnt       <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      work_op   <= '0;
      div_q     <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      div0      <= 1'b0;
    end else if (accept) begin
      ctrl_q    <= dec_code;
      illegal_q <= (dec_kind == K_ILL);
      result_q  <= alu_res;
      hi_q      <= '0;
      cnt       <= '0;
      work_hi   <= '0;
      work_lo   <= dec_div ? mag(bus.i_a, dec_signed) : mag(bus.i_b, dec_signed);
      work_op   <= dec_div ? mag(bus.i_b, dec_signed) : mag(bus.i_a, dec_signed);
      div_q     <= dec_div;
      neg_lo    <= dec_signed && (bus.i_a[DATA_W-1] ^ bus.i_b[DATA_W-1]);
      neg_hi    <= dec_signed && bus.i_a[DATA_W-1];
      div0      <= (bus.i_b == '0);
    end else if (state == BUSY) begin
      work_hi <= step_hi;
      work_lo <= step_lo;
      cnt     <= cnt + CNT_W'(1);
      if (last_iter) begin
        result_q <= fin_result;
        hi_q     <= fin_hi;
      end
    end
  end

  assign bus.o_ready   = (state == IDLE);
  assign bus.o_valid   = (state == DONE);
  assign bus.o_result  = result_q;
  assign bus.o_hi      = hi_q;
  assign bus.o_ALUCtrl = ctrl_q;
  assign bus.o_zero    = (result_q == '0);
  assign bus.o_illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit with DATA_W=32.
module tb_alu_seq_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   lat;
  int   spurious;

  alu_seq_unit_if #(.DATA_W(32)) bus ();

  alu_seq_unit #(.DATA_W(32), .MULDIV_EN(1)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request, scramble inputs after acceptance, wait for o_valid.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.i_Op    = op;
    bus.i_funct = fn;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_a     = 32'hDEADBEEF;
    bus.i_b     = 32'h12345678;
    bus.i_Op    = 6'h3F;
    bus.i_funct = 6'h3F;
    lat = 1;
    while (bus.o_valid !== 1'b1 && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic expect_res(input string tag, input int exp_lat,
                            input logic [31:0] res, input logic [31:0] hi,
                            input logic [3:0] ctrl, input logic ill);
    check({tag, "_lat"},  64'(lat), 64'(exp_lat));
    check({tag, "_res"},  {32'b0, bus.o_result}, {32'b0, res});
    check({tag, "_hi"},   {32'b0, bus.o_hi}, {32'b0, hi});
    check({tag, "_ctrl"}, {60'b0, bus.o_ALUCtrl}, {60'b0, ctrl});
    check({tag, "_ill"},  {63'b0, bus.o_illegal}, {63'b0, ill});
    check({tag, "_zero"}, {63'b0, bus.o_zero}, {63'b0, (res == 32'h0)});
  endtask

  task automatic consume(input string tag);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    check({tag, "_done_valid"}, {63'b0, bus.o_valid}, 64'd0);
    check({tag, "_done_ready"}, {63'b0, bus.o_ready}, 64'd1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    spurious    = 0;
    rst_n       = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_Op    = 6'h0;
    bus.i_funct = 6'h0;
    bus.i_a     = 32'h0;
    bus.i_b     = 32'h0;

    // Asynchronous reset, observed before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", {63'b0, bus.o_ready}, 64'd1);
    check("rst_valid", {63'b0, bus.o_valid}, 64'd0);
    check("rst_result", {32'b0, bus.o_result}, 64'd0);
    check("rst_hi", {32'b0, bus.o_hi}, 64'd0);
    check("rst_ctrl", {60'b0, bus.o_ALUCtrl}, 64'd0);
    check("rst_zero", {63'b0, bus.o_zero}, 64'd1);
    check("rst_ill", {63'b0, bus.o_illegal}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle operations.
    issue(6'b000000, 6'b100000, 32'd5, 32'd7);
    expect_res("add", 1, 32'd12, 32'd0, 4'b1000, 1'b0);
    consume("add");
    issue(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1);
    expect_res("slt", 1, 32'd1, 32'd0, 4'b0101, 1'b0);
    consume("slt");
    issue(6'b000000, 6'b100010, 32'd9, 32'd9);
    expect_res("sub", 1, 32'd0, 32'd0, 4'b1001, 1'b0);
    consume("sub");
    issue(6'b000000, 6'b000000, 32'd1, 32'h24);
    expect_res("sll", 1, 32'd16, 32'd0, 4'b0000, 1'b0);
    consume("sll");
    issue(6'b000000, 6'b000010, 32'h80000000, 32'd31);
    expect_res("srl", 1, 32'd1, 32'd0, 4'b0001, 1'b0);
    consume("srl");
    issue(6'b001100, 6'b010101, 32'h0000F0F0, 32'h000000FF);
    expect_res("andi", 1, 32'h000000F0, 32'd0, 4'b1100, 1'b0);
    consume("andi");
    issue(6'b001010, 6'b000000, 32'd3, 32'hFFFFFFFF);
    expect_res("slti", 1, 32'd0, 32'd0, 4'b0101, 1'b0);
    consume("slti");
    issue(6'b000010, 6'b000000, 32'd44, 32'd55);
    expect_res("j", 1, 32'd0, 32'd0, 4'b0000, 1'b0);
    consume("j");

    // Multi-cycle multiply/divide.
    issue(6'b000000, 6'b011000, 32'hFFFFFFFE, 32'd3);
    expect_res("mult", 33, 32'hFFFFFFFA, 32'hFFFFFFFF, 4'b0010, 1'b0);
    consume("mult");
    issue(6'b000000, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    expect_res("multu", 33, 32'h00000001, 32'hFFFFFFFE, 4'b0011, 1'b0);
    consume("multu");
    issue(6'b000000, 6'b011010, 32'hFFFFFFF9, 32'd2);
    expect_res("div", 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b0110, 1'b0);
    consume("div");
    issue(6'b000000, 6'b011011, 32'd100, 32'd7);
    expect_res("divu", 33, 32'd14, 32'd2, 4'b0111, 1'b0);
    consume("divu");
    issue(6'b000000, 6'b011011, 32'd100, 32'd0);
    expect_res("divu0", 33, 32'hFFFFFFFF, 32'd100, 4'b0111, 1'b0);
    consume("divu0");
    issue(6'b000000, 6'b011010, 32'hFFFFFFF9, 32'd0);
    expect_res("div0", 33, 32'hFFFFFFFF, 32'hFFFFFFF9, 4'b0110, 1'b0);
    consume("div0");

    // Backpressure in DONE with a competing request held on the bus.
    issue(6'b000000, 6'b100000, 32'd3, 32'd4);
    bus.i_Op    = 6'b000000;
    bus.i_funct = 6'b100010;
    bus.i_a     = 32'd50;
    bus.i_b     = 32'd8;
    bus.i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_valid", {63'b0, bus.o_valid}, 64'd1);
      check("bp_ready", {63'b0, bus.o_ready}, 64'd0);
      check("bp_result", {32'b0, bus.o_result}, 64'd7);
      check("bp_ctrl", {60'b0, bus.o_ALUCtrl}, 64'b1000);
    end
    consume("bp");
    bus.i_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp_no_accept", {63'b0, bus.o_valid}, 64'd0);

    // Undecodable requests.
    issue(6'b111111, 6'b100000, 32'd1, 32'd2);
    expect_res("ill_op", 1, 32'd0, 32'd0, 4'b0000, 1'b1);
    consume("ill_op");
    issue(6'b000000, 6'b000001, 32'd1, 32'd2);
    expect_res("ill_fn", 1, 32'd0, 32'd0, 4'b0000, 1'b1);
    consume("ill_fn");

    // Reset in the middle of a multiply aborts it.
    @(negedge clk);
    bus.i_Op    = 6'b000000;
    bus.i_funct = 6'b011000;
    bus.i_a     = 32'd6;
    bus.i_b     = 32'd7;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", {63'b0, bus.o_valid}, 64'd0);
    check("abort_ready", {63'b0, bus.o_ready}, 64'd1);
    check("abort_result", {32'b0, bus.o_result}, 64'd0);
    check("abort_zero", {63'b0, bus.o_zero}, 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid !== 1'b0) spurious++;
    end
    check("abort_stale_valid", 64'(spurious), 64'd0);
    issue(6'b000000, 6'b100000, 32'd2, 32'd2);
    expect_res("post_add", 1, 32'd4, 32'd0, 4'b1000, 1'b0);
    consume("post_add");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width; SHALL be an even value of 8 or more.
REQ-002 Parameter MULDIV_EN, default 1; 1 enables the multi-cycle multiply/divide path, 0 makes those functs illegal.
REQ-003 i_clk  input  1  sole clock, rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  request valid.
REQ-006 o_ready  output  1  unit can accept a request.
REQ-007 i_Op  input  6  opcode.
REQ-008 i_funct  input  6  R-type function field.
REQ-009 i_a, i_b  input  DATA_W each  operands; i_b arrives already immediate-extended by the caller.
REQ-010 o_valid  output  1  result valid.
REQ-011 i_ready  input  1  consumer accepts the result.
REQ-012 o_result  output  DATA_W  result; LO word for multiply, quotient for divide.
REQ-013 o_hi  output  DATA_W  HI word for multiply, remainder for divide, 0 otherwise.
REQ-014 o_ALUCtrl  output  4  registered decode code of the accepted request.
REQ-015 o_zero  output  1  o_result == 0.
REQ-016 o_illegal  output  1  accepted request was undecodable.

Function
REQ-017 Decode SHALL use {i_Op,i_funct}.
- Op 000000 with funct 100000 add: code 1000. 100010 sub: 1001. 100100 and: 1100. 100101 or: 1101. 100110 xor: 1111. 101010 slt: 0101. 000000 sll: 0000. 000010 srl: 0001.
- Op-only: 001000 addi: 1000. 001010 slti: 0101. 001100 andi: 1100. 001101 ori: 1101. 001110 xori: 1111. 100011 lw: 1000. 101011 sw: 1000. 000100 beq: 1001. 000101 bne: 1001. 000010 j: 0000 with result 0.
REQ-018 New R-type functs: 011000 mult: 0010. 011001 multu: 0011. 011010 div: 0110. 011011 divu: 0111.
REQ-019 Any other combination SHALL be illegal: code 0000, o_result 0, o_hi 0, o_illegal 1, 1-cycle latency.
REQ-020 Arithmetic is modulo 2^DATA_W. slt is a signed compare with a zero-extended 0/1 result. The sll/srl shift amount is i_b[log2(DATA_W)-1:0] applied to i_a; srl is logical.
REQ-021 FSM states: IDLE, BUSY, DONE. o_ready=1 only in IDLE.
REQ-022 Accept on i_valid&&o_ready in IDLE.
- Single-cycle op: go to DONE; o_valid=1 on the next cycle.
- mult/div: go to BUSY.
REQ-023 BUSY SHALL run exactly DATA_W iterations: one shift-add step (multiply) or one restoring step (divide) per cycle. It then goes to DONE, so o_valid rises DATA_W+1 cycles after acceptance.
REQ-024 Signed mult/div SHALL operate on magnitudes and fix the sign in the final iteration.
- Quotient truncates toward zero.
- Remainder takes the sign of i_a.
REQ-025 Divide by zero, signed or unsigned, SHALL give quotient all-ones and remainder i_a, with the normal DATA_W+1 latency.
REQ-026 The operands and decode SHALL be captured at acceptance; later changes to i_a, i_b, i_Op and i_funct SHALL NOT affect the result.
REQ-027 DONE SHALL hold o_valid and all result outputs stable until i_ready=1, then return to IDLE. No new request is accepted in that same cycle.
REQ-028 i_valid outside IDLE SHALL be ignored. The requester must hold the request until o_ready.
REQ-029 The iteration counter SHALL be log2(DATA_W)+1 bits wide and SHALL NOT wrap during BUSY.

Reset
REQ-030 While i_rst_n=0, the unit SHALL force:
- state IDLE;
- o_valid, o_result, o_hi, o_illegal and the counter to 0;
- o_ALUCtrl to 0000;
- o_zero to 1;
- o_ready to 1.
This applies immediately, without a clock edge.
REQ-031 Reset during BUSY or DONE SHALL abort the operation. No o_valid pulse for it SHALL appear after release.

Verification (DATA_W=32)
REQ-032 add: Op 000000, funct 100000, a=5, b=7 -> next cycle o_valid=1, o_result=12, o_ALUCtrl=1000, o_zero=0.
REQ-033 slt: a=0xFFFFFFFF, b=1 -> o_result=1. Then sub with a=b=9 -> o_result=0, o_zero=1.
REQ-034 mult: a=0xFFFFFFFE, b=3 -> o_valid exactly 33 cycles after accept, o_hi=0xFFFFFFFF, o_result=0xFFFFFFFA. Signed div -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-035 divu: a=100, b=0 -> o_result=0xFFFFFFFF, o_hi=100, o_illegal=0.
REQ-036 Backpressure: hold i_ready=0 for 5 cycles in DONE -> outputs stable, o_ready=0, extra i_valid ignored. Illegal Op 111111 -> o_illegal=1, o_ALUCtrl=0000.
REQ-037 Reset pulse 10 cycles into a mult -> o_valid=0 and o_ready=1 during reset. After release, no stale o_valid appears and the next add completes normally.
